// File: rtl/seq_mem_playback.sv
// Sequence memory (16 two-bit colours) with timed one-hot lamp playback
// and a combinational read port for the press checker.
module seq_mem_playback #(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_load,
  input  logic [7:0] mem_in,
  input  logic [1:0] mem_load_val,
  input  logic       play_start,
  input  logic [4:0] round_len,
  input  logic [3:0] rd_idx,
  output logic [1:0] rd_colour,
  output logic [3:0] colour_out,
  output logic       play_busy,
  output logic       play_done
);

  localparam int unsigned MEM_W   = 32;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SEQ_MAX = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MEM_W-1:0]   mem_q, mem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [3:0]         colour_q, colour_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   eff_len;

  // Requested length clamped to the memory depth.
  assign eff_len = (round_len > LEN_W'(SEQ_MAX)) ? LEN_W'(SEQ_MAX) : round_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_q    <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      len_q    <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      len_q    <= len_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    len_d    = len_q;
    colour_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_load) begin
          mem_d[{mem_load_val, 3'b000} +: 8] = mem_in;
        end
        if (play_start) begin
          len_d   = eff_len;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = (eff_len == '0) ? S_DONE : S_ON;
        end
      end
      S_ON: begin
        if (tmr_q == CNT_W'(ON_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_OFF;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (tmr_q == CNT_W'(OFF_CYCLES - 1)) begin
          tmr_d = '0;
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_ON;
          end
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs decoded from next state so they register in step with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_ON) begin
      colour_d = 4'd1 << mem_d[{idx_d, 1'b0} +: 2];
    end
  end

  assign rd_colour  = mem_q[{rd_idx, 1'b0} +: 2];
  assign colour_out = colour_q;
  assign play_busy  = busy_q;
  assign play_done  = done_q;

endmodule
